// File: rtl/bcd_scan_driver.sv
// rtl/bcd_scan_driver.sv - two-digit multiplexed seven-segment scan driver
// Double-buffered BCD digits, guard gaps between digits, registered active-low outputs.
module bcd_scan_driver #(
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYCLES  = 16,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic       load,
   input  logic       blank,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_tick
);

   localparam int MAXD = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
   localparam int CW   = $clog2(MAXD);
   localparam logic [CW-1:0] LIT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_ONES = 2'd0,
      S_GAP0 = 2'd1,
      S_TENS = 2'd2,
      S_GAP1 = 2'd3
   } state_t;

   state_t        state, nstate;
   logic [CW-1:0] cnt;
   logic [3:0]    pend_t, pend_o, disp_t, disp_o;
   logic          pend_vld;
   logic [3:0]    nd_t, nd_o;
   logic          last, boundary;
   logic [6:0]    nseg;
   logic [1:0]    nan;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   always_comb begin
      last     = (state == S_ONES || state == S_TENS) ? (cnt == LIT_LAST) : (cnt == GAP_LAST);
      boundary = last && (state == S_GAP1);
      nstate   = state;
      if (last) begin
         case (state)
            S_ONES:  nstate = S_GAP0;
            S_GAP0:  nstate = S_TENS;
            S_TENS:  nstate = S_GAP1;
            default: nstate = S_ONES;
         endcase
      end

      // A load landing on the boundary edge bypasses the pending buffer.
      nd_t = disp_t;
      nd_o = disp_o;
      if (boundary) begin
         if (load) begin
            nd_t = tens;
            nd_o = ones;
         end else if (pend_vld) begin
            nd_t = pend_t;
            nd_o = pend_o;
         end
      end

      nan  = 2'b11;
      nseg = 7'h7F;
      if (!blank) begin
         if (nstate == S_ONES) begin
            nan  = 2'b10;
            nseg = decode(nd_o);
         end else if (nstate == S_TENS && !(BLANK_LZ && nd_t == 4'd0)) begin
            nan  = 2'b01;
            nseg = decode(nd_t);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_GAP1;
         cnt        <= '0;
         pend_t     <= 4'd0;
         pend_o     <= 4'd0;
         pend_vld   <= 1'b0;
         disp_t     <= 4'd0;
         disp_o     <= 4'd0;
         seg        <= 7'h7F;
         an         <= 2'b11;
         frame_tick <= 1'b0;
      end else begin
         state      <= nstate;
         cnt        <= last ? '0 : cnt + 1'b1;
         disp_t     <= nd_t;
         disp_o     <= nd_o;
         if (load) begin
            pend_t <= tens;
            pend_o <= ones;
         end
         pend_vld   <= boundary ? 1'b0 : (load ? 1'b1 : pend_vld);
         seg        <= nseg;
         an         <= nan;
         frame_tick <= boundary;
      end
   end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb/tb_bcd_scan_driver.sv - randomized bench for bcd_scan_driver against a frame-position model
module tb_bcd_scan_driver;

   localparam int R = 4;
   localparam int G = 1;
   localparam int P = 2 * R + 2 * G;
   localparam logic [6:0] SEGTAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] tens = 4'd0, ones = 4'd0;
   logic       load = 1'b0, blank = 1'b0;
   logic [6:0] seg_lz, seg_nl;
   logic [1:0] an_lz, an_nl;
   logic       ft_lz, ft_nl;

   int checks = 0;
   int errors = 0;

   // model: k = edges since reset release; displayed and pending digits
   int         k = 0;
   logic [3:0] m_dt = 4'd0, m_do = 4'd0, m_pt = 4'd0, m_po = 4'd0;
   bit         m_pv = 1'b0, m_bl = 1'b0, m_ft = 1'b0;

   bcd_scan_driver #(.REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LZ(1'b1)) u_lz (
      .clk(clk), .rst_n(rst_n), .tens(tens), .ones(ones), .load(load), .blank(blank),
      .seg(seg_lz), .an(an_lz), .frame_tick(ft_lz));

   bcd_scan_driver #(.REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LZ(1'b0)) u_nl (
      .clk(clk), .rst_n(rst_n), .tens(tens), .ones(ones), .load(load), .blank(blank),
      .seg(seg_nl), .an(an_nl), .frame_tick(ft_nl));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      return (d < 4'd10) ? SEGTAB[d] : 7'h3F;
   endfunction

   function automatic bit is_bnd(input int kk);
      return (kk >= G) && ((kk - G) % P == 0);
   endfunction

   function automatic bit in_tens(input int kk);
      int p;
      if (kk < G) return 1'b0;
      p = (kk - G) % P;
      return (p >= R + G) && (p < 2 * R + G);
   endfunction

   task automatic expect_out(input bit lz, output logic [1:0] ean, output logic [6:0] eseg);
      int p;
      ean  = 2'b11;
      eseg = 7'h7F;
      if (!m_bl && k >= G) begin
         p = (k - G) % P;
         if (p < R) begin
            ean  = 2'b10;
            eseg = ref_seg(m_do);
         end else if (in_tens(k) && !(lz && m_dt == 4'd0)) begin
            ean  = 2'b01;
            eseg = ref_seg(m_dt);
         end
      end
   endtask

   task automatic compare_all();
      logic [1:0] ean;
      logic [6:0] eseg;
      expect_out(1'b1, ean, eseg);
      check("an_lz", 32'(an_lz), 32'(ean));
      check("seg_lz", 32'(seg_lz), 32'(eseg));
      check("tick_lz", 32'(ft_lz), 32'(m_ft));
      expect_out(1'b0, ean, eseg);
      check("an_nolz", 32'(an_nl), 32'(ean));
      check("seg_nolz", 32'(seg_nl), 32'(eseg));
      check("tick_nolz", 32'(ft_nl), 32'(m_ft));
   endtask

   task automatic cyc(input bit ld, input logic [3:0] t, input logic [3:0] o, input bit bl);
      load  = ld;
      tens  = t;
      ones  = o;
      blank = bl;
      @(posedge clk);
      k    = k + 1;
      m_bl = bl;
      m_ft = is_bnd(k);
      if (m_ft) begin
         if (ld) begin
            m_dt = t;
            m_do = o;
         end else if (m_pv) begin
            m_dt = m_pt;
            m_do = m_po;
         end
         m_pv = 1'b0;
      end else if (ld) begin
         m_pt = t;
         m_po = o;
         m_pv = 1'b1;
      end
      #1;
      compare_all();
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0);
   endtask

   task automatic do_reset();
      load  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      k = 0; m_dt = 4'd0; m_do = 4'd0; m_pt = 4'd0; m_po = 4'd0;
      m_pv = 1'b0; m_bl = 1'b0; m_ft = 1'b0;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit bl_r;
      #13;
      do_reset();
      idle(12);
      cyc(1'b1, 4'd4, 4'd2, 1'b0);
      idle(2 * P);
      while (is_bnd(k + 1) || is_bnd(k + 2) || is_bnd(k + 3)) idle(1);
      cyc(1'b1, 4'd1, 4'd7, 1'b0);
      idle(1);
      cyc(1'b1, 4'd9, 4'd3, 1'b0);
      idle(P);
      for (int i = 0; i < P && !is_bnd(k + 1); i++) idle(1);
      cyc(1'b1, 4'd8, 4'd8, 1'b0);
      idle(P);
      cyc(1'b1, 4'd0, 4'd5, 1'b0);
      idle(2 * P);
      cyc(1'b1, 4'd0, 4'd12, 1'b0);
      idle(2 * P);
      for (int i = 0; i < 25; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1);
      idle(P);
      cyc(1'b1, 4'd3, 4'd6, 1'b0);
      idle(P);
      for (int i = 0; i < P && !in_tens(k); i++) idle(1);
      do_reset();
      idle(2 * P);

      bl_r = 1'b0;
      for (int i = 0; i < 800; i++) begin
         logic [3:0] t, o;
         t = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         o = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         if ($urandom_range(0, 19) == 0) bl_r = ~bl_r;
         if ($urandom_range(0, 299) == 0) do_reset();
         cyc($urandom_range(0, 5) == 0, t, o, bl_r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Two-digit multiplexed seven-segment driver that consumes the Tens/Ones BCD nibbles produced by the binary-to-BCD converter and drives a shared active-low segment bus plus two active-low digit anodes. It time-multiplexes the digits with a programmable refresh period and an all-off guard gap between digits to suppress ghosting. It double-buffers the incoming digits so the displayed value changes only on a frame boundary. It sits between the BCD converter and the board pins.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit is lit; legal range ≥2.
- GAP_CYCLES, 16: clock cycles of all-off guard after each digit; legal range ≥1.
- BLANK_LZ, 1: 1 = tens digit dark when it is 0 (and ≤9 rule below); 0 = always shown.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tens  in  4  BCD tens digit from converter.
- ones  in  4  BCD ones digit from converter.
- load  in  1  one-cycle strobe; capture tens/ones as pending value.
- blank  in  1  level; forces both anodes off while high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  2  anodes {tens,ones}, active-low.
- frame_tick  out  1  one-cycle pulse on entry to S_ONES.

## Operation
- Registers: pend_t/pend_o (4b each), pend_vld, disp_t/disp_o (4b each), state (2b), cnt (width clog2(max(REFRESH_DIV,GAP_CYCLES))).
- FSM: S_ONES -> S_GAP0 -> S_TENS -> S_GAP1 -> S_ONES. S_ONES/S_TENS last REFRESH_DIV cycles; gaps last GAP_CYCLES. cnt clears on every transition and advances by 1 per cycle; transition fires when cnt == duration-1.
- Load path: load=1 writes tens/ones into pend_* and sets pend_vld. A load on any non-boundary edge overwrites the previous pending value (last load wins).
- Frame boundary = the S_GAP1->S_ONES edge. On that edge: if load=1, disp_* take tens/ones directly; else if pend_vld, disp_* take pend_*; pend_vld clears in both cases. Otherwise disp_* hold their value.
- Decode (active-low): 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h. Any nibble 10-15 shows dash 3Fh (g only).
- Anode: S_ONES drives an=10b, seg=decode(disp_o). S_TENS drives an=01b, seg=decode(disp_t). Gap states drive an=11b, seg=7Fh.
- Leading-zero blank: when BLANK_LZ=1 and disp_t==0, S_TENS drives an=11b and seg=7Fh.
- blank=1 forces an=11b and seg=7Fh, taking effect on the next edge. The FSM, counter and load path keep running.

## Timing
- Reset (async assert, sync release on clk): state=S_GAP1, cnt=0, disp_*=0, pend_*=0, pend_vld=0, an=11b, seg=7Fh, frame_tick=0.
- The first frame boundary occurs GAP_CYCLES edges after reset release.
- seg, an and frame_tick are registered. They update on the same edge as the state transition and reflect the state being entered.
- Frame period = 2*REFRESH_DIV + 2*GAP_CYCLES cycles. frame_tick is high for exactly the first cycle of each S_ONES.
- Value latency: a load is displayed starting at the next frame boundary. Worst case is one frame period. A load on the boundary edge itself takes 0 extra cycles.
- rst_n assertion mid-frame immediately forces the reset values; pending data is discarded.
- Anodes are never both low; a gap of ≥GAP_CYCLES with an=11b separates every digit change.

## Test plan
- Reset, then REFRESH_DIV=4, GAP_CYCLES=1, no load -> an=11b for 1 cycle; frame_tick pulses; S_ONES shows seg=40h with an=10b for 4 cycles; S_TENS has an=11b (leading-zero blank); period is 10 cycles.
- load with tens=4, ones=2 mid-frame -> display unchanged until next frame_tick; then S_ONES shows seg=24h and S_TENS shows an=01b, seg=19h.
- Two loads (1,7 then 9,3) in the same frame -> next frame shows 9,3 only. A load on the boundary edge (8,8) -> seg=00h is shown in that same frame.
- tens=0, ones=5 with BLANK_LZ=0 -> tens digit lit with 40h. Nibble ones=12 -> seg=3Fh.
- blank held high for 25 cycles -> an=11b throughout; frame_tick keeps pulsing every 10 cycles; the display resumes in phase after blank falls.
- rst_n pulsed low during S_TENS after a load of 3,6 -> outputs go to an=11b, seg=7Fh asynchronously; after release the display shows 0 with the tens digit blanked.
